sd_spi_arbiter: RTL and testbench
=================================

# sd_spi_arbiter

Shares the single SD-card SPI pin set (cs/clk/mosi) between the card initialisation engine and the block-read and block-write engines. The init engine owns the pins from reset until it reports completion. After that, read and write engines request the bus and are granted it round-robin, with a mandatory deselect gap between owners. The block sits between the three SD engines and the top-level SD pins; `sd_miso` is wired to all engines directly and is not muxed here.

## Interface
Parameters:
- `GAP_CYCLES`, 640 — clk_ref cycles of forced deselect between owners (8 SPI clocks at divide-by-80); legal range 1..65535.
- `START_TIMEOUT`, 50000 — clk_ref cycles a grantee may hold `gnt` without raising `busy` before the grant is revoked; legal range 1..65535.

Ports (`name direction width meaning`):
- `clk_ref in 1` — the only clock; all flops on its rising edge.
- `rst in 1` — asynchronous, active-high reset.
- `init_done in 1` — initialisation-complete level from the init engine.
- `init_cs, init_clk, init_mosi in 1` — init engine pin drive.
- `rd_req in 1` — read engine request level.
- `rd_busy in 1` — read engine transfer-in-progress level.
- `rd_cs, rd_clk, rd_mosi in 1` — read engine pin drive.
- `rd_gnt out 1` — read engine grant.
- `wr_req, wr_busy, wr_cs, wr_clk, wr_mosi in 1` — write engine equivalents.
- `wr_gnt out 1` — write engine grant.
- `sd_cs, sd_clk, sd_mosi out 1` — card pins.
- `owner out 2` — current owner: 0 = init, 1 = read, 2 = write, 3 = none (idle/gap).
- `timeout_err out 1` — one-cycle pulse when a grant is revoked by the watchdog.

## Operation
The FSM state is registered.

States and transitions:
- **ST_INIT** (reset state)
  - Pins pass through from `init_*`.
  - Leaves when `init_done` is sampled high → ST_GAP.
- **ST_IDLE**
  - Pins forced to cs=1, clk=1, mosi=1.
  - If `init_done` is low → ST_INIT. This check has priority over requests.
  - Else a request moves to ST_RD or ST_WR.
- **ST_RD / ST_WR**
  - The corresponding `gnt` is high; pins pass through from that engine.
  - The grant is held while `req | busy`.
  - When `req` and `busy` are both sampled low → ST_GAP, with `gnt` low in the same cycle the state changes.
- **ST_GAP**
  - Pins forced idle.
  - Counter runs `GAP_CYCLES` cycles → ST_IDLE.
  - Requests arriving during the gap wait; they are not lost, because `req` is a level.

Arbitration in ST_IDLE:
- Only one request high: that requester wins.
- Both high: the requester not served last wins. `last_rw` resets to "write", so read wins the first tie.
- `last_rw` updates on entry to ST_RD or ST_WR.

Start watchdog:
- A 16-bit counter clears on grant entry and counts while in ST_RD/ST_WR with `busy` never yet seen high.
- On reaching `START_TIMEOUT`: drop `gnt`, pulse `timeout_err`, go to ST_GAP.
- Once `busy` has been seen high during the grant, the watchdog is disarmed for the rest of that grant.

`init_done` falling during ST_RD/ST_WR:
- The current grant completes normally.
- The return to ST_INIT happens from ST_IDLE after the gap.

A requester whose `req` drops before `busy` rises is released only when both are low.

## Timing
- Reset values:
  - State ST_INIT, `owner`=0.
  - `rd_gnt`=0, `wr_gnt`=0, `timeout_err`=0.
  - Counters 0; `last_rw`=write.
  - `sd_*` equal `init_*`, combinationally.
- Pin mux: combinational from the registered state. There is zero latency from the owner's pin inputs to `sd_*`.
- Grant latency: `req` sampled high in ST_IDLE at edge N gives `gnt` high after edge N (one cycle).
- Release: `req`=0 and `busy`=0 sampled at edge N gives `gnt`=0, `owner`=3 and pins idle after edge N.
- Gap: exactly `GAP_CYCLES` cycles in ST_GAP; ST_IDLE is entered at edge N+`GAP_CYCLES`.
- Back-to-back requesters: the earliest next grant is `GAP_CYCLES`+1 cycles after release.
- Timeout: `gnt` drops `START_TIMEOUT` cycles after it rose, with `timeout_err` high for exactly that cycle.
- `rst` asserted mid-grant: everything returns immediately to the reset values and `gnt` drops asynchronously.

## Structure
Shared package `sd_pkg` holds:
- the state encoding constants;
- the owner codes (`OWN_INIT`=0, `OWN_RD`=1, `OWN_WR`=2, `OWN_NONE`=3);
- the idle pin constants (cs=1, clk=1, mosi=1).

These are reused by the SD read/write engines and the top level. The pin mux is a natural sub-module, `sd_pin_mux`: purely combinational, `owner`-selected, driving idle values for `OWN_NONE`. The FSM, gap counter and watchdog stay in the top module.

## Test plan
1. **Reset and init pass-through:** assert `rst`, toggle `init_cs`/`init_mosi` → `sd_*` track `init_*`, `owner`=0, both grants 0.
2. **First grant and gap:** raise `init_done`, then `rd_req` → `owner`=3 for 640 cycles; `rd_gnt` rises on the next cycle after the gap; `sd_*` follow `rd_*`.
3. **Round-robin tie:** `rd_req` and `wr_req` held high together → grants alternate read, write, read, each separated by ≥641 cycles of `owner`=3.
4. **Release timing:** drop `rd_req` while `rd_busy` is high, then drop `rd_busy` → `rd_gnt` stays high until the cycle after `rd_busy` falls.
5. **Start watchdog:** `START_TIMEOUT`=100, `wr_req` high with `wr_busy` never raised → `wr_gnt` falls 100 cycles after rising, `timeout_err` pulses once, then the gap begins.
6. **Re-init and reset mid-grant:** drop `init_done` during a read grant → the read completes, and after the gap `owner`=0. Separately, assert `rst` mid-grant → `rd_gnt`=0 immediately and `owner`=0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD-card SPI definitions: arbiter states, bus owner codes
// and the deselected pin levels.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_GAP  = 3'd4
  } sd_state_e;

  localparam logic [1:0] OWN_INIT = 2'd0;
  localparam logic [1:0] OWN_RD   = 2'd1;
  localparam logic [1:0] OWN_WR   = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  localparam logic IDLE_CS   = 1'b1;
  localparam logic IDLE_CLK  = 1'b1;
  localparam logic IDLE_MOSI = 1'b1;

endpackage

// File: rtl/sd_pin_mux.sv
// Owner-selected SD pin multiplexer; deselected levels when
// nobody owns the bus.
module sd_pin_mux
  import sd_pkg::*;
(
  input  logic [1:0] i_owner,
  input  logic       i_init_cs,
  input  logic       i_init_clk,
  input  logic       i_init_mosi,
  input  logic       i_rd_cs,
  input  logic       i_rd_clk,
  input  logic       i_rd_mosi,
  input  logic       i_wr_cs,
  input  logic       i_wr_clk,
  input  logic       i_wr_mosi,
  output logic       o_sd_cs,
  output logic       o_sd_clk,
  output logic       o_sd_mosi
);

  always_comb begin
    o_sd_cs   = IDLE_CS;
    o_sd_clk  = IDLE_CLK;
    o_sd_mosi = IDLE_MOSI;
    unique case (i_owner)
      OWN_INIT: begin
        o_sd_cs   = i_init_cs;
        o_sd_clk  = i_init_clk;
        o_sd_mosi = i_init_mosi;
      end
      OWN_RD: begin
        o_sd_cs   = i_rd_cs;
        o_sd_clk  = i_rd_clk;
        o_sd_mosi = i_rd_mosi;
      end
      OWN_WR: begin
        o_sd_cs   = i_wr_cs;
        o_sd_clk  = i_wr_clk;
        o_sd_mosi = i_wr_mosi;
      end
      OWN_NONE: begin
        o_sd_cs   = IDLE_CS;
        o_sd_clk  = IDLE_CLK;
        o_sd_mosi = IDLE_MOSI;
      end
    endcase
  end

endmodule

// File: rtl/sd_spi_arbiter.sv
// SD SPI bus arbiter: init engine owns the pins until done, then
// read/write engines share them round-robin with a deselect gap.
module sd_spi_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = 640,
  parameter int unsigned START_TIMEOUT = 50000
) (
  input  logic       clk_ref,
  input  logic       rst,
  input  logic       init_done,
  input  logic       init_cs,
  input  logic       init_clk,
  input  logic       init_mosi,
  input  logic       rd_req,
  input  logic       rd_busy,
  input  logic       rd_cs,
  input  logic       rd_clk,
  input  logic       rd_mosi,
  output logic       rd_gnt,
  input  logic       wr_req,
  input  logic       wr_busy,
  input  logic       wr_cs,
  input  logic       wr_clk,
  input  logic       wr_mosi,
  output logic       wr_gnt,
  output logic       sd_cs,
  output logic       sd_clk,
  output logic       sd_mosi,
  output logic [1:0] owner,
  output logic       timeout_err
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] WD_LAST  = 16'(START_TIMEOUT - 1);

  sd_state_e   r_state;
  sd_state_e   w_state_nxt;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_wd_cnt;
  logic        r_busy_seen;
  logic        r_last_wr;
  logic        r_timeout_err;
  logic        w_granted;
  logic        w_req;
  logic        w_busy;
  logic        w_wd_fire;

  assign w_granted = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_req     = (r_state == ST_WR) ? wr_req  : rd_req;
  assign w_busy    = (r_state == ST_WR) ? wr_busy : rd_busy;

  // Watchdog only bites a grantee that still holds req and never went busy
  assign w_wd_fire = w_granted && w_req && !w_busy &&
                     !r_busy_seen && (r_wd_cnt == WD_LAST);

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:
        if (init_done) w_state_nxt = ST_GAP;
      ST_IDLE:
        if (!init_done)
          w_state_nxt = ST_INIT;
        else if (rd_req && (!wr_req || r_last_wr))
          w_state_nxt = ST_RD;
        else if (wr_req)
          w_state_nxt = ST_WR;
      ST_RD, ST_WR:
        if ((!w_req && !w_busy) || w_wd_fire)
          w_state_nxt = ST_GAP;
      ST_GAP:
        if (r_gap_cnt == GAP_LAST) w_state_nxt = ST_IDLE;
      default:
        w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    owner  = OWN_NONE;
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    case (r_state)
      ST_INIT: owner = OWN_INIT;
      ST_RD: begin
        owner  = OWN_RD;
        rd_gnt = 1'b1;
      end
      ST_WR: begin
        owner  = OWN_WR;
        wr_gnt = 1'b1;
      end
      default: owner = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      r_gap_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_busy_seen   <= 1'b0;
      r_last_wr     <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_wd_fire;
      if (r_state == ST_GAP && w_state_nxt == ST_GAP)
        r_gap_cnt <= r_gap_cnt + 16'd1;
      else
        r_gap_cnt <= '0;
      if (!w_granted) begin
        r_wd_cnt    <= '0;
        r_busy_seen <= 1'b0;
      end else begin
        if (w_busy) r_busy_seen <= 1'b1;
        if (!r_busy_seen && !w_busy) r_wd_cnt <= r_wd_cnt + 16'd1;
      end
      if (r_state == ST_IDLE && w_state_nxt == ST_RD) r_last_wr <= 1'b0;
      if (r_state == ST_IDLE && w_state_nxt == ST_WR) r_last_wr <= 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;

  sd_pin_mux u_mux (
    .i_owner     (owner),
    .i_init_cs   (init_cs),
    .i_init_clk  (init_clk),
    .i_init_mosi (init_mosi),
    .i_rd_cs     (rd_cs),
    .i_rd_clk    (rd_clk),
    .i_rd_mosi   (rd_mosi),
    .i_wr_cs     (wr_cs),
    .i_wr_clk    (wr_clk),
    .i_wr_mosi   (wr_mosi),
    .o_sd_cs     (sd_cs),
    .o_sd_clk    (sd_clk),
    .o_sd_mosi   (sd_mosi)
  );

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Self-checking bench for sd_spi_arbiter: init hand-off, gaps,
// round-robin, release, watchdog, re-init and async reset.
module tb_sd_spi_arbiter;
  import sd_pkg::*;

  localparam int GAP = 640;
  localparam int TMO = 100;
  localparam int BOUND = 3000;

  logic clk_ref = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic init_cs = 1'b1, init_clk = 1'b1, init_mosi = 1'b1;
  logic rd_req = 1'b0, rd_busy = 1'b0;
  logic rd_cs = 1'b1, rd_clk = 1'b1, rd_mosi = 1'b1;
  logic wr_req = 1'b0, wr_busy = 1'b0;
  logic wr_cs = 1'b1, wr_clk = 1'b1, wr_mosi = 1'b1;
  logic rd_gnt, wr_gnt, sd_cs, sd_clk, sd_mosi, timeout_err;
  logic [1:0] owner;

  always #5 clk_ref = ~clk_ref;

  sd_spi_arbiter #(.GAP_CYCLES(GAP), .START_TIMEOUT(TMO)) dut (
    .clk_ref(clk_ref), .rst(rst), .init_done(init_done),
    .init_cs(init_cs), .init_clk(init_clk), .init_mosi(init_mosi),
    .rd_req(rd_req), .rd_busy(rd_busy), .rd_cs(rd_cs),
    .rd_clk(rd_clk), .rd_mosi(rd_mosi), .rd_gnt(rd_gnt),
    .wr_req(wr_req), .wr_busy(wr_busy), .wr_cs(wr_cs),
    .wr_clk(wr_clk), .wr_mosi(wr_mosi), .wr_gnt(wr_gnt),
    .sd_cs(sd_cs), .sd_clk(sd_clk), .sd_mosi(sd_mosi),
    .owner(owner), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [1:0] own;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_run = 0;
  int   n_fail = 0;
  logic model_last_wr = 1'b1;

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  // counts edges until any grant is seen, capped at BOUND
  task automatic wait_gnt(output int n);
    n = 0;
    while (!(rd_gnt | wr_gnt) && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [2:0] p;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p = 3'(i * 3 + 1);
      {init_cs, init_clk, init_mosi} = p;
      #1;
      n_run++;
      if ({sd_cs, sd_clk, sd_mosi} !== p) begin
        n_fail++;
        $display("FAIL reset_passthru got=%b exp=%b", {sd_cs, sd_clk, sd_mosi}, p);
      end
    end
    n_run++;
    if (owner !== OWN_INIT || rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got owner=%0d rg=%b wg=%b te=%b exp 0/0/0/0",
               owner, rd_gnt, wr_gnt, timeout_err);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_run++;
    if (owner !== OWN_INIT) begin
      n_fail++;
      $display("FAIL init_hold got owner=%0d exp=0", owner);
    end
  endtask

  task automatic test_first_grant();
    int n;
    int bad;
    exp_t e;
    logic [2:0] p;
    init_done = 1'b1;
    tick();
    n_run++;
    if (owner !== OWN_NONE) begin
      n_fail++;
      $display("FAIL gap_entry got owner=%0d exp=3", owner);
    end
    rd_req = 1'b1;
    sb_q.push_back('{OWN_RD, GAP + 1});
    model_last_wr = 1'b0;
    n = 0;
    bad = 0;
    while (!(rd_gnt | wr_gnt) && n < BOUND) begin
      tick();
      n++;
      if (!(rd_gnt | wr_gnt) &&
          (owner !== OWN_NONE || {sd_cs, sd_clk, sd_mosi} !== 3'b111))
        bad++;
    end
    n_run++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL gap_idle_pins got %0d bad cycles exp 0", bad);
    end
    e = sb_q.pop_front();
    n_run++;
    if (owner !== e.own || n !== e.lat || rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant got owner=%0d lat=%0d exp owner=%0d lat=%0d",
               owner, n, e.own, e.lat);
    end
    for (int i = 0; i < 4; i++) begin
      p = 3'(i * 5 + 2);
      {rd_cs, rd_clk, rd_mosi} = p;
      {wr_cs, wr_clk, wr_mosi} = ~p;
      {init_cs, init_clk, init_mosi} = ~p;
      #1;
      n_run++;
      if ({sd_cs, sd_clk, sd_mosi} !== p) begin
        n_fail++;
        $display("FAIL rd_passthru got=%b exp=%b", {sd_cs, sd_clk, sd_mosi}, p);
      end
    end
  endtask

  task automatic test_release();
    rd_busy = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_run++;
    if (rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_on_busy got rd_gnt=%b exp=1", rd_gnt);
    end
    rd_busy = 1'b0;
    #1;
    n_run++;
    if (rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL release_early got rd_gnt=%b exp=1", rd_gnt);
    end
    tick();
    n_run++;
    if (rd_gnt !== 1'b0 || owner !== OWN_NONE || {sd_cs, sd_clk, sd_mosi} !== 3'b111) begin
      n_fail++;
      $display("FAIL release got rg=%b owner=%0d pins=%b exp 0/3/111",
               rd_gnt, owner, {sd_cs, sd_clk, sd_mosi});
    end
  endtask

  task automatic test_round_robin();
    int n;
    exp_t e;
    logic [1:0] w;
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = model_last_wr ? OWN_RD : OWN_WR;
      sb_q.push_back('{w, GAP + 1});
      model_last_wr = (w == OWN_WR);
    end
    for (int k = 0; k < 3; k++) begin
      wait_gnt(n);
      e = sb_q.pop_front();
      n_run++;
      if (owner !== e.own || n !== e.lat || (rd_gnt & wr_gnt)) begin
        n_fail++;
        $display("FAIL rr_grant%0d got owner=%0d lat=%0d exp owner=%0d lat=%0d",
                 k, owner, n, e.own, e.lat);
      end
      if (rd_gnt) rd_busy = 1'b1;
      else        wr_busy = 1'b1;
      tick();
      if (rd_gnt) begin
        rd_req = 1'b0;
        rd_busy = 1'b0;
      end else begin
        wr_req = 1'b0;
        wr_busy = 1'b0;
      end
      if (k == 2) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      tick();
      n_run++;
      if (owner !== OWN_NONE) begin
        n_fail++;
        $display("FAIL rr_release%0d got owner=%0d exp=3", k, owner);
      end
      if (k < 2) begin
        rd_req = 1'b1;
        wr_req = 1'b1;
      end
    end
  endtask

  task automatic test_watchdog();
    int n;
    int early;
    exp_t e;
    wr_req = 1'b1;
    sb_q.push_back('{OWN_WR, GAP + 1});
    model_last_wr = 1'b1;
    wait_gnt(n);
    e = sb_q.pop_front();
    n_run++;
    if (owner !== e.own || n !== e.lat) begin
      n_fail++;
      $display("FAIL wd_grant got owner=%0d lat=%0d exp owner=%0d lat=%0d",
               owner, n, e.own, e.lat);
    end
    n = 0;
    early = 0;
    while (wr_gnt && n < BOUND) begin
      if (timeout_err) early++;
      tick();
      n++;
    end
    wr_req = 1'b0;
    n_run++;
    if (n !== TMO || timeout_err !== 1'b1 || owner !== OWN_NONE || early !== 0) begin
      n_fail++;
      $display("FAIL wd_fire got held=%0d te=%b owner=%0d early=%0d exp %0d/1/3/0",
               n, timeout_err, owner, early, TMO);
    end
    tick();
    n_run++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_pulse_len got te=%b exp=0", timeout_err);
    end
  endtask

  task automatic test_reinit();
    int n;
    exp_t e;
    logic [2:0] p;
    rd_req = 1'b1;
    sb_q.push_back('{OWN_RD, GAP});
    model_last_wr = 1'b0;
    wait_gnt(n);
    e = sb_q.pop_front();
    n_run++;
    if (owner !== e.own || n !== e.lat) begin
      n_fail++;
      $display("FAIL reinit_grant got owner=%0d lat=%0d exp owner=%0d lat=%0d",
               owner, n, e.own, e.lat);
    end
    rd_busy = 1'b1;
    init_done = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_run++;
    if (rd_gnt !== 1'b1 || owner !== OWN_RD) begin
      n_fail++;
      $display("FAIL reinit_hold got rg=%b owner=%0d exp 1/1", rd_gnt, owner);
    end
    rd_req = 1'b0;
    rd_busy = 1'b0;
    tick();
    n = 0;
    while (owner !== OWN_INIT && n < BOUND) begin
      tick();
      n++;
    end
    n_run++;
    if (n !== GAP + 1) begin
      n_fail++;
      $display("FAIL reinit_return got %0d cycles exp %0d", n, GAP + 1);
    end
    p = 3'b010;
    {init_cs, init_clk, init_mosi} = p;
    #1;
    n_run++;
    if ({sd_cs, sd_clk, sd_mosi} !== p || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL reinit_pins got pins=%b rg=%b wg=%b exp %b/0/0",
               {sd_cs, sd_clk, sd_mosi}, rd_gnt, wr_gnt, p);
    end
  endtask

  task automatic test_rst_mid_grant();
    int n;
    exp_t e;
    init_done = 1'b1;
    rd_req = 1'b1;
    sb_q.push_back('{OWN_RD, GAP + 2});
    wait_gnt(n);
    e = sb_q.pop_front();
    n_run++;
    if (owner !== e.own || n !== e.lat) begin
      n_fail++;
      $display("FAIL rst_grant got owner=%0d lat=%0d exp owner=%0d lat=%0d",
               owner, n, e.own, e.lat);
    end
    rd_busy = 1'b1;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_run++;
    if (rd_gnt !== 1'b0 || owner !== OWN_INIT ||
        {sd_cs, sd_clk, sd_mosi} !== {init_cs, init_clk, init_mosi}) begin
      n_fail++;
      $display("FAIL rst_async got rg=%b owner=%0d exp 0/0", rd_gnt, owner);
    end
    rd_busy = 1'b0;
    tick();
    rst = 1'b0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    model_last_wr = 1'b1;
    sb_q.push_back('{OWN_RD, GAP + 2});
    wait_gnt(n);
    e = sb_q.pop_front();
    n_run++;
    if (owner !== e.own || n !== e.lat) begin
      n_fail++;
      $display("FAIL rst_tie got owner=%0d lat=%0d exp owner=%0d lat=%0d",
               owner, n, e.own, e.lat);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_release();
    test_round_robin();
    test_watchdog();
    test_reinit();
    test_rst_mid_grant();
    n_run++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got %0d entries exp 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
